// File: rtl/vga_pkg.sv
// Shared timing constants, pixel type and scan FSM encoding for the VGA scan path.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int MEM_LAT_DEF = 0;

   typedef logic [23:0] pixel_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Per-pixel timing bundle carried alongside the vmem read.
   typedef struct packed {
      logic hs;
      logic vs;
      logic bl;
      logic fs;
   } timing_t;

   localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a supplied value.
// DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] rst_val,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, rst_val};
      assign q = d;
   end else begin : g_pipe
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
         end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end

      assign q = stage[DEPTH-1];
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: frame-gated counters address vmem, and sync/blank are delayed
// to meet the returned pixel so the whole VGA output set changes on one register.
module vga_scan_ctrl #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int MEM_LAT  = vga_pkg::MEM_LAT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start,
   output logic        running
);
   import vga_pkg::*;

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   if (MEM_LAT < 0 || MEM_LAT > 3) begin : g_bad_lat
      $error("vga_scan_ctrl: MEM_LAT=%0d outside 0..3", MEM_LAT);
   end
   if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
      $error("vga_scan_ctrl: H_TOTAL=%0d / V_TOTAL=%0d exceed 10-bit counters", H_TOT, V_TOT);
   end

   state_t     state, state_nxt;
   logic [9:0] h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt;
   logic       h_last, v_last, run, active;
   logic [10:0] h_ext, v_ext;
   timing_t    st0, st_dly;
   pixel_t     pix;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);
   assign run    = (state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         h_cnt   <= '0;
         v_cnt   <= '0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         h_cnt   <= h_cnt_nxt;
         v_cnt   <= v_cnt_nxt;
         running <= (state_nxt == RUN);
      end
   end

   // en is only honoured on the last pixel of a frame, so a frame is never cut short.
   always_comb begin
      state_nxt = state;
      h_cnt_nxt = '0;
      v_cnt_nxt = '0;
      case (state)
         IDLE: if (en) state_nxt = RUN;
         RUN: begin
            if (h_last) begin
               v_cnt_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
               if (v_last && !en) state_nxt = IDLE;
            end else begin
               h_cnt_nxt = h_cnt + 10'd1;
               v_cnt_nxt = v_cnt;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign h_ext  = {1'b0, h_cnt};
   assign v_ext  = {1'b0, v_cnt};
   assign active = run && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
   assign h_addr = active ? h_cnt : 10'd0;
   assign v_addr = active ? v_cnt : 10'd0;

   always_comb begin
      st0    = TIMING_IDLE;
      st0.hs = !(run && (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
      st0.vs = !(run && (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
      st0.bl = active;
      st0.fs = run && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   end

   // vmem has no handshake: vga_data for an address is valid exactly MEM_LAT clocks later,
   // which is when the matching timing bundle leaves the delay line.
   vga_delay_line #(
      .DEPTH (MEM_LAT),
      .W     ($bits(timing_t))
   ) u_dly (
      .clk     (clk),
      .rst_n   (rst),
      .rst_val (TIMING_IDLE),
      .d       (st0),
      .q       (st_dly)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank_n     <= 1'b0;
         frame_start <= 1'b0;
         pix         <= '0;
      end else begin
         hsync       <= st_dly.hs;
         vsync       <= st_dly.vs;
         blank_n     <= st_dly.bl;
         frame_start <= st_dly.fs;
         pix         <= st_dly.bl ? vga_data : '0;
      end
   end

   assign vga_r = pix[23:16];
   assign vga_g = pix[15:8];
   assign vga_b = pix[7:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: two instances (vmem latency 0 and 2) on a shrunken raster,
// scored per clock against a frame-index reference model.
module tb_vga_scan_ctrl;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int LAT_A = 0;
   localparam int LAT_B = 2;
   localparam int W = 28;
   localparam logic [W-1:0] IDLE_V = {4'b1100, 24'h000000};

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] data_a, data_b;
   logic [9:0]  h_addr_a, v_addr_a, h_addr_b, v_addr_b;
   logic        hsync_a, vsync_a, blank_n_a, fs_a, running_a;
   logic        hsync_b, vsync_b, blank_n_b, fs_b, running_b;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

   vga_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MEM_LAT(LAT_A)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .vga_data(data_a),
      .h_addr(h_addr_a), .v_addr(v_addr_a), .hsync(hsync_a), .vsync(vsync_a),
      .blank_n(blank_n_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .frame_start(fs_a), .running(running_a)
   );

   vga_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MEM_LAT(LAT_B)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .vga_data(data_b),
      .h_addr(h_addr_b), .v_addr(v_addr_b), .hsync(hsync_b), .vsync(vsync_b),
      .blank_n(blank_n_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .frame_start(fs_b), .running(running_b)
   );

   // vmem models: word encodes its own address
   function automatic logic [23:0] vmem_word(input logic [9:0] h, input logic [9:0] v);
      return {h[7:0], v[7:0], 8'h5A};
   endfunction

   logic [23:0] mem_p1 = '0;
   logic [23:0] mem_p2 = '0;
   assign data_a = vmem_word(h_addr_a, v_addr_a);
   always @(posedge clk) begin
      mem_p1 <= vmem_word(h_addr_b, v_addr_b);
      mem_p2 <= mem_p1;
   end
   assign data_b = mem_p2;

   // reference model: scan position is a single cycle index within the frame
   logic [W-1:0] exp_q_a[$];
   logic [W-1:0] exp_q_b[$];
   bit         m_run = 1'b0;
   int         m_t = 0;
   bit         now_run = 1'b0;
   logic [9:0] now_h = '0;
   logic [9:0] now_v = '0;

   function automatic logic [W-1:0] expect_out(input bit run, input int t);
      int col, line;
      bit act, hs, vs, fs;
      logic [23:0] rgb;
      col  = t % HT;
      line = t / HT;
      act  = run && (col < HA) && (line < VA);
      hs   = !(run && (col >= HA + HF) && (col < HA + HF + HS));
      vs   = !(run && (line >= VA + VF) && (line < VA + VF + VS));
      fs   = run && (t == 0);
      rgb  = act ? {col[7:0], line[7:0], 8'h5A} : 24'h000000;
      return {hs, vs, act, fs, rgb};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run = 1'b0;
         m_t   = 0;
         exp_q_a.delete();
         exp_q_b.delete();
         for (int i = 0; i < LAT_A + 2; i++) exp_q_a.push_back(IDLE_V);
         for (int i = 0; i < LAT_B + 2; i++) exp_q_b.push_back(IDLE_V);
      end else begin
         if (!m_run) begin
            if (en) begin
               m_run = 1'b1;
               m_t   = 0;
            end
         end else if (m_t == FRAME - 1) begin
            m_t   = 0;
            m_run = en;
         end else begin
            m_t = m_t + 1;
         end
         exp_q_a.push_back(expect_out(m_run, m_t));
         exp_q_b.push_back(expect_out(m_run, m_t));
      end
      now_run = m_run;
      if (m_run && (m_t % HT) < HA && (m_t / HT) < VA) begin
         now_h = 10'(m_t % HT);
         now_v = 10'(m_t / HT);
      end else begin
         now_h = '0;
         now_v = '0;
      end
   end

   // scoreboard / monitor: sole owner of the check counters
   int checks = 0;
   int errors = 0;
   int timeouts = 0;
   bit done = 1'b0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      while (!done) begin
         @(negedge clk or negedge rst);
         #1;
         if (exp_q_a.size() > LAT_A + 1)
            cmp("dut_a out {hs,vs,bl,fs,rgb}", 32'({hsync_a, vsync_a, blank_n_a, fs_a, r_a, g_a, b_a}),
                32'(exp_q_a.pop_front()));
         if (exp_q_b.size() > LAT_B + 1)
            cmp("dut_b out {hs,vs,bl,fs,rgb}", 32'({hsync_b, vsync_b, blank_n_b, fs_b, r_b, g_b, b_b}),
                32'(exp_q_b.pop_front()));
         cmp("dut_a h_addr", 32'(h_addr_a), 32'(now_h));
         cmp("dut_a v_addr", 32'(v_addr_a), 32'(now_v));
         cmp("dut_b h_addr", 32'(h_addr_b), 32'(now_h));
         cmp("dut_b v_addr", 32'(v_addr_b), 32'(now_v));
         cmp("dut_a running", 32'(running_a), 32'(now_run));
         cmp("dut_b running", 32'(running_b), 32'(now_run));
      end
      cmp("wait-for-idle timeouts", 32'(timeouts), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // driver tasks
   task automatic wait_idle();
      for (int i = 0; i < 2 * FRAME && running_a; i++) @(negedge clk);
      if (running_a) timeouts++;
   endtask

   task automatic async_reset_pulse();
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      // idle with en low
      repeat (300) @(negedge clk);

      // two full frames plus a bit
      @(negedge clk);
      en = 1'b1;
      repeat (2 * FRAME + $urandom_range(0, HT)) @(negedge clk);

      // drop en mid-frame; scan must finish the frame and drain
      en = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      // restart, then async reset mid-frame with en held high
      en = 1'b1;
      repeat ($urandom_range(FRAME / 2, FRAME - HT)) @(negedge clk);
      async_reset_pulse();
      repeat (FRAME + 10) @(negedge clk);

      // seamless continuation across a frame boundary, then stop exactly at one
      repeat (FRAME) @(negedge clk);
      en = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);

      // randomized en toggling with occasional resets
      for (int k = 0; k < 10; k++) begin
         en = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, FRAME + 50)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) async_reset_pulse();
      end

      en = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);
      done = 1'b1;
   end

endmodule
